// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in serial-out frame transmitter with load handshake
// Optional even-parity trailer bit enabled by `define PISO_TX_PARITY_EN.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_done;
    logic             r_load_ready;
`ifdef PISO_TX_PARITY_EN
    logic             r_parity;
`endif

    logic             w_load;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_din_adv;
    logic [WIDTH-1:0] w_shift_adv;

    // The outgoing bit always sits at the exit end; the register advances toward it.
    assign w_load      = load_valid & r_load_ready & (r_state == S_IDLE);
    assign w_first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_din_adv   = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
    assign w_shift_adv = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_load) begin
                        r_shift      <= w_din_adv;
                        r_sout       <= w_first_bit;
                        r_sout_valid <= 1'b1;
                        r_cnt        <= '0;
                        r_load_ready <= 1'b0;
                        r_state      <= S_SHIFT;
`ifdef PISO_TX_PARITY_EN
                        r_parity     <= ^din;
`endif
                    end else begin
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        r_load_ready <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == LAST_IDX) begin
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_shift <= w_shift_adv;
`ifdef PISO_TX_PARITY_EN
                        r_sout  <= (r_cnt == DATA_LAST) ? r_parity : w_next_bit;
`else
                        r_sout  <= w_next_bit;
`endif
                    end
                end
                S_DONE: begin
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_sout       <= 1'b0;
                    r_sout_valid <= 1'b0;
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign done       = r_done;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb/tb_piso_shift_tx.sv - scoreboard bench for piso_shift_tx, MSB-first and LSB-first instances
// Expected frame length follows `define PISO_TX_PARITY_EN.
module tb_piso_shift_tx;

    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] din;

    logic m_load_ready, m_sout, m_sout_valid, m_busy, m_done;
    logic l_load_ready, l_sout, l_sout_valid, l_busy, l_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic q_m[$];
    logic q_l[$];

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(m_load_ready), .sout(m_sout), .sout_valid(m_sout_valid),
        .busy(m_busy), .done(m_done)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(l_load_ready), .sout(l_sout), .sout_valid(l_sout_valid),
        .busy(l_busy), .done(l_done)
    );

    function automatic void push_frame(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            q_m.push_back(w[W-1-i]);
            q_l.push_back(w[i]);
        end
`ifdef PISO_TX_PARITY_EN
        q_m.push_back(^w);
        q_l.push_back(^w);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        load_valid = 1'b0;
        din = '0;
        #7;
        n_checks++;
        if ({m_sout, m_sout_valid, m_busy, m_done, m_load_ready} === 5'b0 &&
            {l_sout, l_sout_valid, l_busy, l_done, l_load_ready} === 5'b0) n_pass++;
        else $display("FAIL reset_state msb=%b lsb=%b required 00000",
                      {m_sout, m_sout_valid, m_busy, m_done, m_load_ready},
                      {l_sout, l_sout_valid, l_busy, l_done, l_load_ready});
        #5 rst = 1'b1;
        #1;
        n_checks++;
        if (m_load_ready === 1'b0) n_pass++;
        else $display("FAIL ready_before_edge got %b required 0", m_load_ready);
        @(negedge clk);
        n_checks++;
        if (m_load_ready === 1'b1 && l_load_ready === 1'b1) n_pass++;
        else $display("FAIL ready_after_release got %b/%b required 1/1", m_load_ready, l_load_ready);
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({m_sout_valid, m_busy, m_done, l_sout_valid, l_busy, l_done} === 6'b0 &&
                m_load_ready === 1'b1) n_pass++;
            else $display("FAIL idle_cycle%0d got v/b/d=%b%b%b ready=%b required 000 ready=1",
                          c, m_sout_valid, m_busy, m_done, m_load_ready);
        end
    endtask

    // Entered at a negedge with load_ready high; leaves at the next such negedge.
    task automatic test_single_frame(input logic [W-1:0] word);
        logic em, el;
        din = word;
        load_valid = 1'b1;
        push_frame(word);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        din = W'($urandom);
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            em = q_m.pop_front();
            el = q_l.pop_front();
            n_checks++;
            if (m_sout_valid === 1'b1 && m_sout === em && m_busy === 1'b1 && m_load_ready === 1'b0) n_pass++;
            else $display("FAIL msb_frame word=%h bit%0d got sout=%b valid=%b required sout=%b valid=1",
                          word, i, m_sout, m_sout_valid, em);
            n_checks++;
            if (l_sout_valid === 1'b1 && l_sout === el) n_pass++;
            else $display("FAIL lsb_frame word=%h bit%0d got sout=%b valid=%b required sout=%b valid=1",
                          word, i, l_sout, l_sout_valid, el);
        end
        @(negedge clk);
        n_checks++;
        if (m_done === 1'b1 && l_done === 1'b1 && m_sout_valid === 1'b0 && m_sout === 1'b0 &&
            m_busy === 1'b1 && m_load_ready === 1'b0) n_pass++;
        else $display("FAIL done_cycle word=%h got done=%b valid=%b busy=%b ready=%b required 1 0 1 0",
                      word, m_done, m_sout_valid, m_busy, m_load_ready);
        @(negedge clk);
        n_checks++;
        if (m_load_ready === 1'b1 && l_load_ready === 1'b1 && m_done === 1'b0 && m_busy === 1'b0) n_pass++;
        else $display("FAIL ready_return word=%h got ready=%b done=%b busy=%b required 1 0 0",
                      word, m_load_ready, m_done, m_busy);
    endtask

    task automatic test_back_to_back();
        logic em, el;
        din = 8'hFF;
        load_valid = 1'b1;
        push_frame(8'hFF);
        push_frame(8'h00);
        @(posedge clk);
        #1 din = 8'h00;
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < F; i++) begin
                @(negedge clk);
                em = q_m.pop_front();
                el = q_l.pop_front();
                n_checks++;
                if (m_sout_valid === 1'b1 && m_sout === em && l_sout_valid === 1'b1 && l_sout === el) n_pass++;
                else $display("FAIL b2b_frame%0d bit%0d got msb=%b lsb=%b valid=%b required %b %b 1",
                              fr, i, m_sout, l_sout, m_sout_valid, em, el);
            end
            @(negedge clk);
            n_checks++;
            if (m_done === 1'b1 && m_sout_valid === 1'b0 && m_load_ready === 1'b0) n_pass++;
            else $display("FAIL b2b_done%0d got done=%b valid=%b ready=%b required 1 0 0",
                          fr, m_done, m_sout_valid, m_load_ready);
            @(negedge clk);
            n_checks++;
            if (m_load_ready === 1'b1 && m_sout_valid === 1'b0 && m_done === 1'b0) n_pass++;
            else $display("FAIL b2b_gap%0d got ready=%b valid=%b done=%b required 1 0 0",
                          fr, m_load_ready, m_sout_valid, m_done);
            if (fr == 0) begin
                @(posedge clk);
                #1 load_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midframe();
        din = 8'hA5;
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({m_sout, m_sout_valid, m_busy, m_done, m_load_ready} === 5'b0 &&
            {l_sout, l_sout_valid, l_busy, l_done, l_load_ready} === 5'b0) n_pass++;
        else $display("FAIL midframe_reset msb=%b lsb=%b required 00000",
                      {m_sout, m_sout_valid, m_busy, m_done, m_load_ready},
                      {l_sout, l_sout_valid, l_busy, l_done, l_load_ready});
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_load_ready === 1'b1 && m_busy === 1'b0) n_pass++;
        else $display("FAIL midframe_ready got ready=%b busy=%b required 1 0", m_load_ready, m_busy);
        for (int c = 0; c < F + 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (m_done === 1'b0 && l_done === 1'b0 && m_sout_valid === 1'b0) n_pass++;
            else $display("FAIL midframe_no_done cycle%0d got done=%b valid=%b required 0 0",
                          c, m_done, m_sout_valid);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_frame(8'h3A);
        test_single_frame(8'h07);
        test_back_to_back();
        for (int k = 0; k < 4; k++) test_single_frame(W'($urandom));
        test_reset_midframe();
        test_single_frame(8'hC9);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d/%0d checks required completion", n_pass, n_checks);
        $fatal(1);
    end

endmodule
